// File: rtl/mode_sequencer.sv
// mode_sequencer: serialises selector mode changes, settles, captures and hands off the operands
module mode_sequencer #(
  parameter int N = 8,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  input  logic [2:0]   op_mode,
  output logic         op_ready,
  output logic [2:0]   select,
  input  logic [N-1:0] sel_out1,
  input  logic [N-1:0] sel_out2,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res1,
  output logic [N-1:0] res2,
  output logic         res_err,
  output logic         busy,
  output logic [7:0]   op_count
);
  typedef enum logic [1:0] {IDLE, SETL, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic acc, bad, fin;
  assign op_ready = state == IDLE;
  assign busy = !op_ready;
  assign res_valid = state == DONE;
  assign acc = op_valid & op_ready;
  assign bad = op_mode[2] & op_mode[1];
  assign fin = state == SETL && cnt == 4'd0;
  always_comb begin
    state_nx = acc ? (bad ? DONE : SETL) : fin ? DONE : (res_valid && res_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 4'd0;
      select <= 3'd0;
      res1 <= '0;
      res2 <= '0;
      res_err <= 1'b0;
      op_count <= 8'd0;
    end else begin
      if (acc) begin
        select <= op_mode;
        cnt <= 4'(SETTLE - 1);
        res_err <= bad;
      end
      // illegal modes never sample the selector
      if (acc && bad) begin
        res1 <= '0;
        res2 <= '0;
      end
      if (state == SETL && !fin) cnt <= cnt - 4'd1;
      if (fin) begin
        res1 <= sel_out1;
        res2 <= sel_out2;
      end
      if (res_valid && res_ready) op_count <= op_count + 8'd1;
    end
endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: directed checks of mode_sequencer against a stand-in selector
module tb_mode_sequencer;
  logic clk = 0, rst_n = 1, op_valid = 0, res_ready = 0;
  logic [2:0] op_mode = 0, select;
  logic [7:0] sel_out1, sel_out2, res1, res2, op_count, tog = 0;
  logic op_ready, res_valid, res_err, busy;
  int total = 0, bad = 0;
  logic [7:0] e1 [8] = '{8'h0A, 8'h0A, 8'h01, 8'h0A, 8'h0A, 8'h0A, 8'h00, 8'h00};
  logic [7:0] e2 [8] = '{8'h00, 8'h00, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00};

  mode_sequencer #(.N(8), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_mode(op_mode), .op_ready(op_ready),
    .select(select), .sel_out1(sel_out1), .sel_out2(sel_out2), .res_valid(res_valid),
    .res_ready(res_ready), .res1(res1), .res2(res2), .res_err(res_err), .busy(busy),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // selector fed in1=00 in2=01 in3=0A in4=0B; illegal codes drive junk that must never be captured
  always_comb begin
    sel_out1 = ((select == 3'd2) ? 8'h01 : (select[2] & select[1]) ? 8'hEE : 8'h0A) ^ tog;
    sel_out2 = (select == 3'd3) ? 8'h0B : (select[2] & select[1]) ? 8'hEE : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst;
    #2 rst_n = 0;
    #1 rst_n = 1;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    chk(tag, res_valid, 1);
  endtask

  initial begin
    #2 rst_n = 0;
    #1;
    chk("rst_select", select, 0);
    chk("rst_res1", res1, 0);
    chk("rst_res2", res2, 0);
    chk("rst_err", res_err, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_count", op_count, 0);
    chk("rst_ready", op_ready, 1);
    chk("rst_busy", busy, 0);
    #1 rst_n = 1;
    step();
    // single mode 010 op with exact latency
    op_mode = 3'd2; op_valid = 1; res_ready = 1;
    step();
    op_valid = 0;
    chk("m2_select", select, 3'd2);
    chk("m2_ready", op_ready, 0);
    chk("m2_busy", busy, 1);
    chk("m2_valid_t0", res_valid, 0);
    step();
    chk("m2_valid_t1", res_valid, 0);
    step();
    chk("m2_valid_t2", res_valid, 1);
    chk("m2_res1", res1, 8'h01);
    chk("m2_res2", res2, 8'h00);
    chk("m2_err", res_err, 0);
    chk("m2_count_pre", op_count, 0);
    step();
    chk("m2_valid_drop", res_valid, 0);
    chk("m2_ready_back", op_ready, 1);
    chk("m2_count", op_count, 1);
    // all modes back to back
    pulse_rst();
    chk("all_rst_count", op_count, 0);
    chk("all_rst_select", select, 0);
    op_valid = 1; res_ready = 1;
    for (int m = 0; m < 8; m++) begin
      op_mode = 3'(m);
      step();
      chk("all_select", select, m);
      for (int n = 0; n < 20 && !res_valid; n++) begin
        chk("all_ready_low", op_ready, 0);
        step();
      end
      chk("all_valid", res_valid, 1);
      chk("all_res1", res1, e1[m]);
      chk("all_res2", res2, e2[m]);
      chk("all_err", res_err, m >= 6);
      chk("all_ready_done", op_ready, 0);
      step();
      chk("all_ready_back", op_ready, 1);
    end
    op_valid = 0;
    chk("all_count", op_count, 8);
    // backpressure on mode 011
    res_ready = 0; op_mode = 3'd3; op_valid = 1;
    step();
    op_valid = 0;
    wait_res("bp_valid");
    for (int i = 0; i < 10; i++) begin
      tog = ~tog; op_valid = ~op_valid; op_mode = 3'd5;
      step();
      chk("bp_res1", res1, 8'h0A);
      chk("bp_res2", res2, 8'h0B);
      chk("bp_ready", op_ready, 0);
      chk("bp_select", select, 3'd3);
      chk("bp_valid_hold", res_valid, 1);
    end
    tog = 0; op_valid = 0; res_ready = 1;
    step();
    chk("bp_ready_back", op_ready, 1);
    chk("bp_count", op_count, 9);
    chk("bp_select_kept", select, 3'd3);
    step();
    chk("bp_no_queue", op_ready, 1);
    chk("bp_count_idle", op_count, 9);
    // abort during settle
    pulse_rst();
    op_mode = 3'd3; op_valid = 1; res_ready = 1;
    step();
    op_valid = 0;
    chk("ab_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("ab_valid", res_valid, 0);
    chk("ab_count", op_count, 0);
    chk("ab_select", select, 0);
    chk("ab_ready", op_ready, 1);
    rst_n = 1;
    step(); step(); step();
    chk("ab_valid_later", res_valid, 0);
    chk("ab_count_later", op_count, 0);
    op_mode = 3'd4; op_valid = 1;
    step();
    op_valid = 0;
    wait_res("ab2_valid");
    chk("ab2_res1", res1, 8'h0A);
    chk("ab2_res2", res2, 8'h00);
    chk("ab2_err", res_err, 0);
    step();
    chk("ab2_count", op_count, 1);
    // counter wrap
    pulse_rst();
    op_mode = 3'd7; op_valid = 1; res_ready = 1;
    repeat (255) begin
      step();
      step();
    end
    chk("wrap_255", op_count, 8'hFF);
    step();
    step();
    chk("wrap_0", op_count, 0);
    op_valid = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
